// File: rtl/fifo_pkg.sv
// Shared helpers for the parameterised FIFO: width derivation and a
// parameter legality check that the FIFO elaborates as a fatal error.
package fifo_pkg;

    // Pointer width: one bit per address line of the storage array.
    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy width: one extra bit so that count can reach DEPTH.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // DEPTH must be a power of two (pointers wrap naturally) and at least 4;
    // thresholds must lie in range and not overlap.
    function automatic bit params_ok(input int depth, input int af, input int ae);
        return is_pow2(depth) && (depth >= 4) &&
               (af >= 1) && (af <= depth) &&
               (ae >= 0) && (ae < depth) &&
               (ae < af);
    endfunction

endpackage

// File: rtl/ram_dp_sync.sv
// DEPTH x DATA_W simple dual-port RAM: one write port, one registered read
// port. Read-first on address collision; the array itself is never reset,
// only the read register.
module ram_dp_sync
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; no reset so the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; sampling mem before the write lands gives read-first,
    // and the register holds its value when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered read data, occupancy count,
// programmable almost-full/almost-empty thresholds and overflow/underflow
// pulses. Pointer, count and flag logic live here; storage is ram_dp_sync.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    if (!params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $fatal(1, "sync_fifo_param: illegal DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count_nxt;
    logic              wr_acc, rd_acc;

    // A read needs data; a write into a full FIFO is only legal when a read
    // frees a slot in the same cycle.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    // Next occupancy; simultaneous accepted read and write cancel out.
    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers, count and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
            count     <= count_nxt;
            rd_valid  <= rd_acc;
            overflow  <= wr_en & ~wr_acc;
            underflow <= rd_en & ~rd_acc;
        end
    end

    // Status flags decoded from next count and registered, so each flag is a
    // flop output and tracks count in the same cycle without glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            full         <= (count_nxt == CNT_W'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CNT_W'(AF_THRESH));
            almost_empty <= (count_nxt <= CNT_W'(AE_THRESH));
        end
    end

    ram_dp_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

endmodule
